aes_uart_ctrl: RTL and testbench
================================

// Module: aes_uart_ctrl
// PURPOSE
//  Sequencer between the UART hex receiver and the AES-256 core. Latches the 256-bit key and 128-bit text
//  strobed in by the receiver, starts the core, captures the 128-bit result and streams it to the UART
//  transmitter as 32 ASCII hex chars (MSB nibble first), optionally followed by CR LF.
//  Errors (text without key, core timeout) answer with the single char 'E' (+ CR LF).
// PARAMETERS
//  TIMEOUT_CYCLES  1048576  max cycles waiting for i_aes_done before error; 0 = no timeout
//  SEND_CRLF       1        1: append 0x0D,0x0A after each response; 0: no terminator
//  UPPERCASE       1        1: hex A-F as 0x41-0x46; 0: as 0x61-0x66
// PORTS
//  clk_i            in   1    system clock
//  reset_n          in   1    asynchronous active-low reset
//  i_metin          in   128  text from receiver
//  i_metin_valid    in   1    1-cycle strobe, i_metin valid
//  i_anahtar        in   256  key from receiver
//  i_anahtar_valid  in   1    1-cycle strobe, i_anahtar valid
//  o_aes_key        out  256  key held for AES core
//  o_aes_block      out  128  text held for AES core
//  o_aes_start      out  1    1-cycle start pulse to AES core
//  i_aes_done       in   1    1-cycle done strobe from AES core
//  i_aes_result     in   128  ciphertext, valid with i_aes_done
//  o_tx_byte        out  8    byte to UART transmitter
//  o_tx_dv          out  1    1-cycle strobe, o_tx_byte valid
//  i_tx_done        in   1    1-cycle strobe, transmitter finished byte
//  o_key_loaded     out  1    a key has been latched since reset
//  o_busy           out  1    high in every state except S_IDLE
//  o_overrun        out  1    1-cycle pulse: strobe dropped while busy
// BEHAVIOUR
//  Reset (reset_n=0, async): all outputs and registers 0, state S_IDLE.
//  All outputs registered. Key: i_anahtar_valid in S_IDLE -> o_aes_key<=i_anahtar, o_key_loaded<=1.
//  States: S_IDLE, S_START, S_WAIT_AES, S_SEND, S_WAIT_TX, S_EOL.
//   S_IDLE: i_metin_valid & key_loaded -> latch o_aes_block, go S_START.
//           i_metin_valid & !key_loaded -> load response 'E', go S_SEND (1 char).
//           Same-cycle key+text strobes: key latched, text uses the new key (no 'E').
//   S_START: o_aes_start high exactly this cycle; clear timeout counter; -> S_WAIT_AES.
//     Latency: i_metin_valid sampled at edge k -> o_aes_start high after edge k+1 for one cycle.
//   S_WAIT_AES: i_aes_done -> capture i_aes_result into 128-bit shift reg, char count=32, -> S_SEND.
//     Counter reaches TIMEOUT_CYCLES (nonzero) -> response 'E', -> S_SEND. Done wins if same cycle.
//   S_SEND: o_tx_byte = hex(shift[127:124]) (or 'E'), o_tx_dv pulsed one cycle; -> S_WAIT_TX.
//   S_WAIT_TX: wait i_tx_done; then shift left 4, count-1; count>0 -> S_SEND;
//     else SEND_CRLF ? S_EOL : S_IDLE. o_tx_dv never re-asserted before i_tx_done.
//   S_EOL: send 0x0D then 0x0A, each with same dv/done handshake; -> S_IDLE.
//  Hex map: 0-9 -> 0x30-0x39; A-F per UPPERCASE.
//  i_metin_valid or i_anahtar_valid while o_busy: ignored (key/text regs unchanged), o_overrun pulse.
//  o_aes_key/o_aes_block stable from S_START until return to S_IDLE.
//  i_aes_done outside S_WAIT_AES ignored. i_tx_done outside wait states ignored.
//  Reset asserted mid-operation: immediate return to idle values; no further tx/start pulses;
//   o_key_loaded cleared (key must be resent).
// TESTING
//  T1 FIPS-197: key 000102..1e1f, text 00112233445566778899aabbccddeeff, model returns
//     8ea2b7ca516745bfeafc49904b496089 -> tx "8EA2B7CA516745BFEAFC49904B496089",0x0D,0x0A; one start pulse.
//  T2 text strobe with no key since reset -> tx 0x45,0x0D,0x0A; o_aes_start never high.
//  T3 TIMEOUT_CYCLES=100, core never done -> 'E',CR,LF after 100 cycles in S_WAIT_AES; back to idle.
//  T4 key strobe during tx of T1 -> o_overrun pulse, o_aes_key unchanged; next text uses old key.
//  T5 UPPERCASE=0, SEND_CRLF=0, result 0x...ff -> last char 0x66, exactly 32 bytes sent.
//  T6 reset_n low after 5th tx char -> outputs 0 at once; after release, text strobe -> 'E' (key lost).

Source files
------------

// File: rtl/aes_uart_ctrl_if.sv
// Bus bundle between the AES/UART sequencer and its receiver, AES core and transmitter.
interface aes_uart_ctrl_if;
  logic [127:0] i_metin;
  logic         i_metin_valid;
  logic [255:0] i_anahtar;
  logic         i_anahtar_valid;
  logic [255:0] o_aes_key;
  logic [127:0] o_aes_block;
  logic         o_aes_start;
  logic         i_aes_done;
  logic [127:0] i_aes_result;
  logic [7:0]   o_tx_byte;
  logic         o_tx_dv;
  logic         i_tx_done;
  logic         o_key_loaded;
  logic         o_busy;
  logic         o_overrun;

  // Environment side: receiver, AES core and transmitter.
  modport master (
    output i_metin, i_metin_valid, i_anahtar, i_anahtar_valid,
    output i_aes_done, i_aes_result, i_tx_done,
    input  o_aes_key, o_aes_block, o_aes_start, o_tx_byte, o_tx_dv,
    input  o_key_loaded, o_busy, o_overrun
  );

  // Sequencer side.
  modport slave (
    input  i_metin, i_metin_valid, i_anahtar, i_anahtar_valid,
    input  i_aes_done, i_aes_result, i_tx_done,
    output o_aes_key, o_aes_block, o_aes_start, o_tx_byte, o_tx_dv,
    output o_key_loaded, o_busy, o_overrun
  );
endinterface

// File: rtl/aes_uart_ctrl.sv
// Sequencer: latches key/text from the hex receiver, runs the AES core and
// streams the 128-bit result to the UART transmitter as 32 ASCII hex chars.
module aes_uart_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1048576,
  parameter bit          SEND_CRLF      = 1'b1,
  parameter bit          UPPERCASE      = 1'b1
) (
  input  logic           clk_i,
  input  logic           reset_n,
  aes_uart_ctrl_if.slave bus
);

  localparam int unsigned TMO_W   = 32;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned N_CHARS = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_AES,
    S_SEND,
    S_WAIT_TX,
    S_EOL
  } state_t;

  state_t             state;
  logic [255:0]       key_q;
  logic [127:0]       block_q;
  logic [127:0]       shift_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [7:0]         tx_byte_q;
  logic               tx_dv_q;
  logic               aes_start_q;
  logic               key_loaded_q;
  logic               busy_q;
  logic               overrun_q;
  logic               err_q;
  logic               in_eol_q;
  logic               eol_lf_q;

  // Nibble to ASCII hex character.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10)  return 8'h30 + 8'(n);
    else if (UPPERCASE) return 8'h41 + 8'(n - 4'd10);
    else            return 8'h61 + 8'(n - 4'd10);
  endfunction

  // Main sequencer: state, handshake pulses and datapath registers.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      key_q        <= '0;
      block_q      <= '0;
      shift_q      <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      tx_byte_q    <= '0;
      tx_dv_q      <= 1'b0;
      aes_start_q  <= 1'b0;
      key_loaded_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      err_q        <= 1'b0;
      in_eol_q     <= 1'b0;
      eol_lf_q     <= 1'b0;
    end else begin
      aes_start_q <= 1'b0;
      tx_dv_q     <= 1'b0;
      overrun_q   <= (state != S_IDLE) && (bus.i_metin_valid || bus.i_anahtar_valid);

      case (state)
        S_IDLE: begin
          if (bus.i_anahtar_valid) begin
            key_q        <= bus.i_anahtar;
            key_loaded_q <= 1'b1;
          end
          if (bus.i_metin_valid) begin
            busy_q <= 1'b1;
            // A key arriving in the same cycle counts as loaded.
            if (key_loaded_q || bus.i_anahtar_valid) begin
              block_q <= bus.i_metin;
              err_q   <= 1'b0;
              state   <= S_START;
            end else begin
              err_q <= 1'b1;
              cnt_q <= CNT_W'(1);
              state <= S_SEND;
            end
          end
        end

        S_START: begin
          aes_start_q <= 1'b1;
          tmo_q       <= '0;
          state       <= S_WAIT_AES;
        end

        S_WAIT_AES: begin
          if (bus.i_aes_done) begin
            shift_q <= bus.i_aes_result;
            cnt_q   <= CNT_W'(N_CHARS);
            err_q   <= 1'b0;
            state   <= S_SEND;
          end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == (TIMEOUT_CYCLES - 32'd1))) begin
            err_q <= 1'b1;
            cnt_q <= CNT_W'(1);
            state <= S_SEND;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        S_SEND: begin
          tx_byte_q <= err_q ? 8'h45 : hex_char(shift_q[127:124]);
          tx_dv_q   <= 1'b1;
          in_eol_q  <= 1'b0;
          state     <= S_WAIT_TX;
        end

        S_WAIT_TX: begin
          if (bus.i_tx_done) begin
            if (in_eol_q) begin
              if (eol_lf_q) begin
                busy_q <= 1'b0;
                state  <= S_IDLE;
              end else begin
                eol_lf_q <= 1'b1;
                state    <= S_EOL;
              end
            end else begin
              shift_q <= {shift_q[123:0], 4'h0};
              cnt_q   <= cnt_q - CNT_W'(1);
              if (cnt_q > CNT_W'(1)) begin
                state <= S_SEND;
              end else if (SEND_CRLF) begin
                eol_lf_q <= 1'b0;
                state    <= S_EOL;
              end else begin
                busy_q <= 1'b0;
                state  <= S_IDLE;
              end
            end
          end
        end

        S_EOL: begin
          tx_byte_q <= eol_lf_q ? 8'h0A : 8'h0D;
          tx_dv_q   <= 1'b1;
          in_eol_q  <= 1'b1;
          state     <= S_WAIT_TX;
        end

        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_aes_key    = key_q;
  assign bus.o_aes_block  = block_q;
  assign bus.o_aes_start  = aes_start_q;
  assign bus.o_tx_byte    = tx_byte_q;
  assign bus.o_tx_dv      = tx_dv_q;
  assign bus.o_key_loaded = key_loaded_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_overrun    = overrun_q;

endmodule

// File: tb/tb_aes_uart_ctrl.sv
// Directed bench for aes_uart_ctrl: two instances (default-like and lowercase/no-CRLF),
// each with a small AES-core model and a UART transmitter responder.
module tb_aes_uart_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_uart_ctrl_if bus_a ();
  aes_uart_ctrl_if bus_b ();

  aes_uart_ctrl #(.TIMEOUT_CYCLES(100), .SEND_CRLF(1'b1), .UPPERCASE(1'b1)) dut_a (
    .clk_i(clk), .reset_n(rst_n), .bus(bus_a)
  );

  aes_uart_ctrl #(.TIMEOUT_CYCLES(0), .SEND_CRLF(1'b0), .UPPERCASE(1'b0)) dut_b (
    .clk_i(clk), .reset_n(rst_n), .bus(bus_b)
  );

  int n_checks = 0;
  int n_fail = 0;
  int proto_err = 0;
  int start_a = 0, start_b = 0;
  int tcd_a = 0, tcd_b = 0, acd_a = 0, acd_b = 0;
  logic aes_en_a = 1'b1;
  logic [127:0] res_a = '0, res_b = '0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  localparam logic [255:0] KEY1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY2 = 256'hdeadbeefdeadbeefdeadbeefdeadbeefdeadbeefdeadbeefdeadbeefdeadbeef;
  localparam logic [255:0] KEY3 = 256'h55555555555555555555555555555555aaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa;
  localparam logic [127:0] TXT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] TXT2 = 128'hcafef00dcafef00dcafef00dcafef00d;

  // Transmitter and AES-core responders for instance A.
  always @(negedge clk) begin
    bus_a.i_tx_done  = 1'b0;
    bus_a.i_aes_done = 1'b0;
    if (!rst_n) begin
      tcd_a = 0;
      acd_a = 0;
    end else begin
      if (bus_a.o_tx_dv) begin
        if (tcd_a > 0) proto_err++;
        qa.push_back(bus_a.o_tx_byte);
        tcd_a = 3;
      end else if (tcd_a > 0) begin
        tcd_a--;
        if (tcd_a == 0) bus_a.i_tx_done = 1'b1;
      end
      if (bus_a.o_aes_start) begin
        start_a++;
        if (aes_en_a) acd_a = 4;
      end else if (acd_a > 0) begin
        acd_a--;
        if (acd_a == 0) begin
          bus_a.i_aes_done   = 1'b1;
          bus_a.i_aes_result = res_a;
        end
      end
    end
  end

  // Transmitter and AES-core responders for instance B.
  always @(negedge clk) begin
    bus_b.i_tx_done  = 1'b0;
    bus_b.i_aes_done = 1'b0;
    if (!rst_n) begin
      tcd_b = 0;
      acd_b = 0;
    end else begin
      if (bus_b.o_tx_dv) begin
        if (tcd_b > 0) proto_err++;
        qb.push_back(bus_b.o_tx_byte);
        tcd_b = 3;
      end else if (tcd_b > 0) begin
        tcd_b--;
        if (tcd_b == 0) bus_b.i_tx_done = 1'b1;
      end
      if (bus_b.o_aes_start) begin
        start_b++;
        acd_b = 4;
      end else if (acd_b > 0) begin
        acd_b--;
        if (acd_b == 0) begin
          bus_b.i_aes_done   = 1'b1;
          bus_b.i_aes_result = res_b;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One-cycle strobe of key and/or text, starting and ending just after a falling edge.
  task automatic pulse(input int sel, input bit k, input bit t,
                       input logic [255:0] key, input logic [127:0] txt);
    if (sel == 0) begin
      bus_a.i_anahtar = key; bus_a.i_anahtar_valid = k;
      bus_a.i_metin = txt;   bus_a.i_metin_valid = t;
    end else begin
      bus_b.i_anahtar = key; bus_b.i_anahtar_valid = k;
      bus_b.i_metin = txt;   bus_b.i_metin_valid = t;
    end
    @(negedge clk);
    bus_a.i_anahtar_valid = 1'b0; bus_a.i_metin_valid = 1'b0;
    bus_b.i_anahtar_valid = 1'b0; bus_b.i_metin_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int sel, input int n, input string tag);
    int sz;
    sz = (sel == 0) ? qa.size() : qb.size();
    for (int i = 0; i < 3000 && sz < n; i++) begin
      @(negedge clk);
      sz = (sel == 0) ? qa.size() : qb.size();
    end
    check({tag, "_bytes"}, 256'(sz >= n), 256'(1));
  endtask

  task automatic wait_idle(input int sel, input string tag);
    logic b;
    b = (sel == 0) ? bus_a.o_busy : bus_b.o_busy;
    for (int i = 0; i < 200 && b; i++) begin
      @(negedge clk);
      b = (sel == 0) ? bus_a.o_busy : bus_b.o_busy;
    end
    check({tag, "_idle"}, 256'(b), 256'(0));
  endtask

  // Collect a full response and compare it byte by byte with the expected hex string.
  task automatic check_resp(input int sel, input string hex, input bit crlf, input string tag);
    logic [7:0] q[$];
    logic [7:0] exp;
    int n;
    n = hex.len() + (crlf ? 2 : 0);
    wait_bytes(sel, n, tag);
    wait_idle(sel, tag);
    repeat (8) @(negedge clk);
    if (sel == 0) q = qa; else q = qb;
    check({tag, "_count"}, 256'(q.size()), 256'(n));
    for (int i = 0; i < n && i < q.size(); i++) begin
      if (i < hex.len()) exp = hex[i];
      else exp = (i == hex.len()) ? 8'h0D : 8'h0A;
      check($sformatf("%s[%0d]", tag, i), 256'(q[i]), 256'(exp));
    end
    if (sel == 0) qa.delete(); else qb.delete();
  endtask

  initial begin
    int lat;
    int s0;
    bus_a.i_metin = '0; bus_a.i_metin_valid = 1'b0; bus_a.i_anahtar = '0; bus_a.i_anahtar_valid = 1'b0;
    bus_b.i_metin = '0; bus_b.i_metin_valid = 1'b0; bus_b.i_anahtar = '0; bus_b.i_anahtar_valid = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_busy", 256'(bus_a.o_busy), 256'(0));
    check("rst_keyld", 256'(bus_a.o_key_loaded), 256'(0));
    check("rst_dv", 256'(bus_a.o_tx_dv), 256'(0));
    check("rst_start", 256'(bus_a.o_aes_start), 256'(0));
    check("rst_key", bus_a.o_aes_key, 256'(0));
    check("rst_block", 256'(bus_a.o_aes_block), 256'(0));
    check("rst_txbyte", 256'(bus_a.o_tx_byte), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // T2: text with no key -> 'E' CR LF, no start.
    pulse(0, 1'b0, 1'b1, '0, TXT1);
    check_resp(0, "E", 1'b1, "t2");
    check("t2_nostart", 256'(start_a), 256'(0));

    // T1: FIPS-197 vector, start latency and one-cycle start pulse.
    res_a = 128'h8ea2b7ca516745bfeafc49904b496089;
    pulse(0, 1'b1, 1'b0, KEY1, '0);
    check("t1_keyld", 256'(bus_a.o_key_loaded), 256'(1));
    check("t1_key", bus_a.o_aes_key, KEY1);
    bus_a.i_metin = TXT1; bus_a.i_metin_valid = 1'b1;
    @(negedge clk);
    bus_a.i_metin_valid = 1'b0;
    check("t1_start_k", 256'(bus_a.o_aes_start), 256'(0));
    check("t1_busy", 256'(bus_a.o_busy), 256'(1));
    @(negedge clk);
    check("t1_start_k1", 256'(bus_a.o_aes_start), 256'(1));
    check("t1_block", 256'(bus_a.o_aes_block), 256'(TXT1));
    @(negedge clk);
    check("t1_start_end", 256'(bus_a.o_aes_start), 256'(0));

    // T4: key strobe during transmission is dropped with an overrun pulse.
    wait_bytes(0, 3, "t4_mid");
    pulse(0, 1'b1, 1'b0, KEY2, '0);
    check("t4_overrun", 256'(bus_a.o_overrun), 256'(1));
    @(negedge clk);
    check("t4_overrun_end", 256'(bus_a.o_overrun), 256'(0));
    check("t4_key_kept", bus_a.o_aes_key, KEY1);
    check_resp(0, "8EA2B7CA516745BFEAFC49904B496089", 1'b1, "t1");
    check("t1_one_start", 256'(start_a), 256'(1));

    res_a = 128'h0123456789abcdeffedcba9876543210;
    pulse(0, 1'b0, 1'b1, '0, TXT2);
    @(negedge clk);
    check("t4_old_key", bus_a.o_aes_key, KEY1);
    check_resp(0, "0123456789ABCDEFFEDCBA9876543210", 1'b1, "t4b");

    // T3: core never answers -> 'E' after 100 cycles waiting.
    aes_en_a = 1'b0;
    pulse(0, 1'b0, 1'b1, '0, TXT1);
    for (int i = 0; i < 10 && !bus_a.o_aes_start; i++) @(negedge clk);
    lat = 0;
    while (!bus_a.o_tx_dv && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("t3_latency", 256'(lat), 256'(101));
    check_resp(0, "E", 1'b1, "t3");
    aes_en_a = 1'b1;

    // T6: reset mid-transmission clears everything, key is lost.
    s0 = start_a;
    res_a = 128'hffffffffffffffffffffffffffffffff;
    pulse(0, 1'b0, 1'b1, '0, TXT1);
    wait_bytes(0, 5, "t6_mid");
    rst_n = 1'b0;
    #1;
    check("t6_dv", 256'(bus_a.o_tx_dv), 256'(0));
    check("t6_busy", 256'(bus_a.o_busy), 256'(0));
    check("t6_keyld", 256'(bus_a.o_key_loaded), 256'(0));
    check("t6_key", bus_a.o_aes_key, 256'(0));
    check("t6_txbyte", 256'(bus_a.o_tx_byte), 256'(0));
    repeat (10) @(negedge clk);
    check("t6_no_more_tx", 256'(qa.size()), 256'(5));
    rst_n = 1'b1;
    qa.delete();
    @(negedge clk);
    pulse(0, 1'b0, 1'b1, '0, TXT1);
    check_resp(0, "E", 1'b1, "t6");
    check("t6_starts", 256'(start_a), 256'(s0 + 1));

    // Same-cycle key and text: the new key is used, no error.
    res_a = 128'h00000000000000000000000000000001;
    pulse(0, 1'b1, 1'b1, KEY3, TXT2);
    check_resp(0, "00000000000000000000000000000001", 1'b1, "same");
    check("same_key", bus_a.o_aes_key, KEY3);

    // T5: lowercase, no CR LF, exactly 32 bytes.
    res_b = 128'h000102030405060708090a0b0c0d0eff;
    pulse(1, 1'b1, 1'b1, KEY1, TXT1);
    check_resp(1, "000102030405060708090a0b0c0d0eff", 1'b0, "t5");
    repeat (20) @(negedge clk);
    check("t5_no_extra", 256'(qb.size()), 256'(0));
    check("t5_starts", 256'(start_b), 256'(1));

    check("proto_dv_before_done", 256'(proto_err), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
